param_rr_arbiter_mux: RTL and testbench
=======================================

// Module: param_rr_arbiter_mux
// PURPOSE
//  Round-robin arbiter and registered one-hot channel selector. It shares one
//  DATA_WIDTH output stream between INPUT_CHANNELS valid/ready requesters.
//  It generates the one-hot select for the channel mux internally and applies
//  per-grant burst limits. It sits in front of single-consumer datapaths that
//  are fed by several producers.
// PARAMETERS
//  DATA_WIDTH      8  width of each channel word and of out_data
//  INPUT_CHANNELS  4  number of requesters (>=2)
//  BURST_LEN       1  max consecutive beats per grant before forced re-arbitration (>=1)
// PORTS
//  clk       in   1                          single clock, all state on rising edge
//  rst_n     in   1                          asynchronous, active-low reset
//  in_valid  in   INPUT_CHANNELS             per-channel request/valid
//  in_data   in   INPUT_CHANNELS*DATA_WIDTH  channel i at [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]
//  in_ready  out  INPUT_CHANNELS             one-hot (or zero) accept strobe
//  out_valid out  1                          output register holds a word
//  out_data  out  DATA_WIDTH                 registered selected word
//  out_chan  out  $clog2(INPUT_CHANNELS)     source index of out_data
//  out_ready in   1                          downstream accept
//  grant     out  INPUT_CHANNELS             one-hot current owner; 0 when IDLE
// BEHAVIOUR
//  - Reset values: out_valid=0, out_data=0, out_chan=0, grant=0, ptr=0, cnt=0.
//  - While rst_n=0, in_ready is forced to 0 combinationally.
//  - load = !out_valid | out_ready, i.e. the output register can take a word this cycle.
//  - Select sel (one-hot, combinational):
//      * if grant!=0 and in_valid[owner]: sel = grant;
//      * otherwise: sel = the first set in_valid bit, searching from index ptr upward
//        and wrapping modulo INPUT_CHANNELS;
//      * sel = 0 if no in_valid bit is set.
//  - in_ready = load ? sel : 0.
//  - Accept: load & |sel. On accept, out_data <= selected word, out_chan <= idx(sel),
//    out_valid <= 1. A word appears at the output 1 cycle after acceptance.
//  - load & ~|sel & out_ready: out_valid <= 0.
//  - !load: out_* are held unchanged, all in_ready=0, and grant/cnt/ptr are frozen.
//  - FSM IDLE (grant==0) / OWN (grant!=0):
//      * accept in IDLE -> OWN: grant<=sel, cnt<=1.
//      * accept in OWN from the owner: cnt<=cnt+1.
//      * accept in OWN from another channel (owner dropped valid): grant<=sel, cnt<=1.
//        The switch happens with no bubble cycle.
//      * if the post-accept cnt equals BURST_LEN: -> IDLE, grant<=0, cnt<=0,
//        ptr <= (idx(sel)+1) mod INPUT_CHANNELS. This overrides the two rules above.
//      * OWN with load=1, owner valid low and no accept: -> IDLE, ptr <= owner+1 mod N.
//  - ptr wraps from INPUT_CHANNELS-1 to 0.
//  - BURST_LEN=1 gives pure round-robin, one beat per grant.
//  - A requester that keeps in_valid high is served again once all other requesters
//    have had their turn. Starvation-free.
//  - in_data must be stable while in_valid=1 and in_ready=0.
//  - out_data/out_chan are stable while out_valid=1 and out_ready=0.
//  - Reset asserted mid-transfer clears all state immediately. The pending output
//    word is dropped.
// TESTING
//  1. rst_n low with out_valid=1 and grant=0100 -> same cycle: out_valid=0, grant=0,
//     in_ready=0. After release the first pick starts from ch0.
//  2. N=4, BURST_LEN=1, in_valid=1111, out_ready=1 -> out_chan 0,1,2,3,0,1...
//     One word per cycle after a 1-cycle latency.
//  3. N=4, BURST_LEN=2, in_valid=1111, out_ready=1 -> out_chan 0,0,1,1,2,2,3,3,0.
//  4. out_valid=1 with out_data=8'hA5 and out_ready=0 for 3 cycles -> out_data=8'hA5,
//     out_chan unchanged, in_ready=0000 throughout. Then out_ready=1 -> next word is
//     accepted that same cycle.
//  5. BURST_LEN=2, only ch2 valid continuously -> ch2 accepted every cycle. grant
//     toggles 0100 -> 0 at each burst end, then is re-granted to ch2 with no idle cycle.
//  6. BURST_LEN=4, ch1 owner at cnt=1, ch1 drops valid while ch3 is valid ->
//     in_ready=1000 that cycle, grant=1000, cnt=1. No empty output cycle.

Source files
------------

// File: rtl/param_rr_arbiter_mux.sv
// param_rr_arbiter_mux
// Round-robin arbiter feeding a registered output stage. Several valid/ready
// producers share one output word register. A grant may be held for up to
// BURST_LEN consecutive beats. After that the search pointer moves past the
// owner, so every other requester gets a turn before the owner is served again.
module param_rr_arbiter_mux #(
   parameter int DATA_WIDTH     = 8,
   parameter int INPUT_CHANNELS = 4,
   parameter int BURST_LEN      = 1
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [INPUT_CHANNELS-1:0]            in_valid,
   input  logic [INPUT_CHANNELS*DATA_WIDTH-1:0] in_data,
   output logic [INPUT_CHANNELS-1:0]            in_ready,
   output logic                                 out_valid,
   output logic [DATA_WIDTH-1:0]                out_data,
   output logic [$clog2(INPUT_CHANNELS)-1:0]    out_chan,
   input  logic                                 out_ready,
   output logic [INPUT_CHANNELS-1:0]            grant
);

   localparam int PW = $clog2(INPUT_CHANNELS);
   localparam int CW = $clog2(BURST_LEN + 1);
   localparam logic [INPUT_CHANNELS-1:0] ONE_HOT0 = {{(INPUT_CHANNELS-1){1'b0}}, 1'b1};

   // Ownership state is carried by grant itself: zero means nobody owns the output.
   typedef enum logic {ST_IDLE = 1'b0, ST_OWN = 1'b1} state_t;

   logic                      out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0]     out_data_q,  out_data_d;
   logic [PW-1:0]             out_chan_q,  out_chan_d;
   logic [INPUT_CHANNELS-1:0] grant_q,     grant_d;
   logic [PW-1:0]             ptr_q,       ptr_d;
   logic [CW-1:0]             cnt_q,       cnt_d;

   state_t                    state_s;
   logic                      load_s;
   logic                      accept_s;
   logic                      owner_valid_s;
   logic [PW-1:0]             owner_idx_s;
   logic [PW-1:0]             rr_idx_s;
   logic [PW-1:0]             sel_idx_s;
   logic [INPUT_CHANNELS-1:0] sel_s;
   logic [DATA_WIDTH-1:0]     word_s;
   logic [CW-1:0]             cnt_post_s;

   // Channel index reached by stepping k places up from base, wrapping at the channel count.
   function automatic logic [PW-1:0] rot_idx(input logic [PW-1:0] base, input int k);
      return PW'((int'(base) + k) % INPUT_CHANNELS);
   endfunction

   // Channel index that follows i, wrapping from the last channel back to channel 0.
   function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
      return (i == PW'(INPUT_CHANNELS - 1)) ? '0 : i + 1'b1;
   endfunction

   assign state_s  = (grant_q != '0) ? ST_OWN : ST_IDLE;
   assign load_s   = !out_valid_q || out_ready;
   assign accept_s = load_s && (sel_s != '0);
   assign in_ready = (rst_n && load_s) ? sel_s : '0;

   // Pick the channel: the owner keeps priority while it is valid, otherwise do a rotating search from ptr.
   always_comb begin
      owner_idx_s = '0;
      for (int i = 0; i < INPUT_CHANNELS; i++) begin
         owner_idx_s = owner_idx_s | (grant_q[i] ? PW'(i) : '0);
      end
      owner_valid_s = |(grant_q & in_valid);
      // Walk downwards so that the candidate closest to ptr is the one kept.
      rr_idx_s = '0;
      for (int k = INPUT_CHANNELS - 1; k >= 0; k--) begin
         rr_idx_s = in_valid[rot_idx(ptr_q, k)] ? rot_idx(ptr_q, k) : rr_idx_s;
      end
      sel_idx_s = '0;
      sel_s     = '0;
      if (owner_valid_s) begin
         sel_idx_s = owner_idx_s;
         sel_s     = grant_q;
      end else if (in_valid != '0) begin
         sel_idx_s = rr_idx_s;
         sel_s     = ONE_HOT0 << rr_idx_s;
      end else begin
         sel_idx_s = '0;
         sel_s     = '0;
      end
   end

   // One-hot OR mux of the selected channel word.
   always_comb begin
      word_s = '0;
      for (int i = 0; i < INPUT_CHANNELS; i++) begin
         word_s = word_s | (sel_s[i] ? in_data[i*DATA_WIDTH +: DATA_WIDTH] : '0);
      end
   end

   // Next state for the output register, the grant, the burst counter and the search pointer.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_chan_d  = out_chan_q;
      grant_d     = grant_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      cnt_post_s  = {{(CW-1){1'b0}}, 1'b1};
      if (accept_s) begin
         out_valid_d = 1'b1;
         out_data_d  = word_s;
         out_chan_d  = sel_idx_s;
         case (state_s)
            ST_OWN:  cnt_post_s = owner_valid_s ? cnt_q + 1'b1 : {{(CW-1){1'b0}}, 1'b1};
            ST_IDLE: cnt_post_s = {{(CW-1){1'b0}}, 1'b1};
            default: cnt_post_s = {{(CW-1){1'b0}}, 1'b1};
         endcase
         // A finished burst always releases the grant and moves the pointer past the channel just served.
         if (cnt_post_s == CW'(BURST_LEN)) begin
            grant_d = '0;
            cnt_d   = '0;
            ptr_d   = next_idx(sel_idx_s);
         end else begin
            grant_d = sel_s;
            cnt_d   = cnt_post_s;
         end
      end else if (load_s) begin
         // Nothing to send: the register drains, and an owner that went quiet gives up its grant.
         out_valid_d = 1'b0;
         grant_d     = '0;
         cnt_d       = '0;
         ptr_d       = (state_s == ST_OWN) ? next_idx(owner_idx_s) : ptr_q;
      end else begin
         // Downstream is stalled: everything keeps its value.
         out_valid_d = out_valid_q;
         grant_d     = grant_q;
      end
   end

   // State registers; reset clears any pending output word immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_chan_q  <= '0;
         grant_q     <= '0;
         ptr_q       <= '0;
         cnt_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_chan_q  <= out_chan_d;
         grant_q     <= grant_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_chan  = out_chan_q;
   assign grant     = grant_q;

endmodule

// File: tb/tb_param_rr_arbiter_mux.sv
// Bench for param_rr_arbiter_mux: three instances (BURST_LEN 1, 2, 4) share the
// same stimulus. Each instance is compared every cycle against a per-instance
// behavioural model. Directed table vectors and corner sequences add literal checks.
module tb_param_rr_arbiter_mux;
   localparam int N  = 4;
   localparam int DW = 8;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic [3:0]  in_valid  = 4'b0;
   logic [31:0] in_data   = 32'h0;
   logic        out_ready = 1'b0;

   logic [3:0] rdy [3];
   logic       ov  [3];
   logic [7:0] od  [3];
   logic [1:0] oc  [3];
   logic [3:0] gnt [3];

   param_rr_arbiter_mux #(.DATA_WIDTH(DW), .INPUT_CHANNELS(N), .BURST_LEN(1)) u_bl1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy[0]),
      .out_valid(ov[0]), .out_data(od[0]), .out_chan(oc[0]), .out_ready(out_ready), .grant(gnt[0]));
   param_rr_arbiter_mux #(.DATA_WIDTH(DW), .INPUT_CHANNELS(N), .BURST_LEN(2)) u_bl2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy[1]),
      .out_valid(ov[1]), .out_data(od[1]), .out_chan(oc[1]), .out_ready(out_ready), .grant(gnt[1]));
   param_rr_arbiter_mux #(.DATA_WIDTH(DW), .INPUT_CHANNELS(N), .BURST_LEN(4)) u_bl4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy[2]),
      .out_valid(ov[2]), .out_data(od[2]), .out_chan(oc[2]), .out_ready(out_ready), .grant(gnt[2]));

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state, one set per instance.
   int         m_bl    [3];
   int         m_owner [3];   // -1 when nobody owns the output
   int         m_cnt   [3];
   int         m_ptr   [3];
   bit         m_ov    [3];
   logic [7:0] m_od    [3];
   int         m_oc    [3];
   logic [3:0] pre_rdy [3];   // in_ready sampled just before the last edge

   typedef struct {
      logic [3:0] iv;
      logic       ordy;
      logic [3:0] rdy1;
      logic [1:0] chan1;
      logic [3:0] rdy2;
      logic [1:0] chan2;
      logic [3:0] gnt2;
   } vec_t;
   vec_t tbl [9];

   task automatic check(input string name, input int b, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (BURST_LEN=%0d): got %0h, expected %0h", name, m_bl[b], act, exp);
      end
   endtask

   function automatic int m_pick(input int b, input logic [3:0] iv);
      if (m_owner[b] >= 0 && iv[m_owner[b]]) return m_owner[b];
      for (int k = 0; k < N; k++) begin
         if (iv[(m_ptr[b] + k) % N]) return (m_ptr[b] + k) % N;
      end
      return -1;
   endfunction

   task automatic model_reset();
      for (int b = 0; b < 3; b++) begin
         m_owner[b] = -1; m_cnt[b] = 0; m_ptr[b] = 0;
         m_ov[b] = 1'b0; m_od[b] = 8'h00; m_oc[b] = 0;
      end
   endtask

   // Apply one cycle of stimulus (called just after a rising edge), check in_ready,
   // advance the model, then check the registered outputs after the edge.
   task automatic cycle(input logic [3:0] iv, input logic ordy, input logic [31:0] data);
      in_valid = iv; out_ready = ordy; in_data = data;
      #3;
      for (int b = 0; b < 3; b++) begin
         int s;
         bit ld;
         logic [3:0] er;
         s  = m_pick(b, iv);
         ld = !m_ov[b] || ordy;
         er = (ld && s >= 0) ? 4'(1 << s) : 4'b0000;
         pre_rdy[b] = rdy[b];
         check("in_ready", b, 32'(rdy[b]), 32'(er));
         if (ld) begin
            if (s >= 0) begin
               m_ov[b] = 1'b1;
               m_od[b] = data[s*8 +: 8];
               m_oc[b] = s;
               m_cnt[b] = (s == m_owner[b]) ? m_cnt[b] + 1 : 1;
               m_owner[b] = s;
               if (m_cnt[b] == m_bl[b]) begin
                  m_owner[b] = -1; m_cnt[b] = 0; m_ptr[b] = (s + 1) % N;
               end
            end else begin
               m_ov[b] = 1'b0;
               if (m_owner[b] >= 0) begin
                  m_ptr[b] = (m_owner[b] + 1) % N; m_owner[b] = -1; m_cnt[b] = 0;
               end
            end
         end
      end
      @(posedge clk);
      #1;
      for (int b = 0; b < 3; b++) begin
         check("out_valid", b, 32'(ov[b]), 32'(m_ov[b]));
         check("out_data",  b, 32'(od[b]), 32'(m_od[b]));
         check("out_chan",  b, 32'(oc[b]), 32'(m_oc[b]));
         check("grant",     b, 32'(gnt[b]), (m_owner[b] >= 0) ? 32'(1 << m_owner[b]) : 32'h0);
      end
   endtask

   task automatic do_reset();
      in_valid = 4'b0; out_ready = 1'b0; in_data = 32'h0;
      rst_n = 1'b0;
      model_reset();
      #2;
      for (int b = 0; b < 3; b++) begin
         check("reset out_valid", b, 32'(ov[b]), 32'h0);
         check("reset out_data",  b, 32'(od[b]), 32'h0);
         check("reset out_chan",  b, 32'(oc[b]), 32'h0);
         check("reset grant",     b, 32'(gnt[b]), 32'h0);
      end
      @(posedge clk); #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      m_bl[0] = 1; m_bl[1] = 2; m_bl[2] = 4;
      // All four channels requesting with a free output: BURST_LEN 1 rotates per beat, BURST_LEN 2 per pair.
      tbl[0] = '{4'b1111, 1'b1, 4'b0001, 2'd0, 4'b0001, 2'd0, 4'b0001};
      tbl[1] = '{4'b1111, 1'b1, 4'b0010, 2'd1, 4'b0001, 2'd0, 4'b0000};
      tbl[2] = '{4'b1111, 1'b1, 4'b0100, 2'd2, 4'b0010, 2'd1, 4'b0010};
      tbl[3] = '{4'b1111, 1'b1, 4'b1000, 2'd3, 4'b0010, 2'd1, 4'b0000};
      tbl[4] = '{4'b1111, 1'b1, 4'b0001, 2'd0, 4'b0100, 2'd2, 4'b0100};
      tbl[5] = '{4'b1111, 1'b1, 4'b0010, 2'd1, 4'b0100, 2'd2, 4'b0000};
      tbl[6] = '{4'b1111, 1'b1, 4'b0100, 2'd2, 4'b1000, 2'd3, 4'b1000};
      tbl[7] = '{4'b1111, 1'b1, 4'b1000, 2'd3, 4'b1000, 2'd3, 4'b0000};
      tbl[8] = '{4'b1111, 1'b1, 4'b0001, 2'd0, 4'b0001, 2'd0, 4'b0001};

      #1;
      do_reset();

      for (int k = 0; k < 9; k++) begin
         cycle(tbl[k].iv, tbl[k].ordy, 32'h13121110);
         check("tbl in_ready", 0, 32'(pre_rdy[0]), 32'(tbl[k].rdy1));
         check("tbl out_chan", 0, 32'(oc[0]), 32'(tbl[k].chan1));
         check("tbl out_data", 0, 32'(od[0]), 32'h10 + 32'(tbl[k].chan1));
         check("tbl in_ready", 1, 32'(pre_rdy[1]), 32'(tbl[k].rdy2));
         check("tbl out_chan", 1, 32'(oc[1]), 32'(tbl[k].chan2));
         check("tbl grant",    1, 32'(gnt[1]), 32'(tbl[k].gnt2));
      end

      // Output stall: word A5 from ch1 held for three cycles, then the next word goes straight in.
      cycle(4'b0010, 1'b1, 32'h3322A511);
      check("stall load data", 0, 32'(od[0]), 32'hA5);
      for (int i = 0; i < 3; i++) begin
         cycle(4'b1111, 1'b0, 32'h3322A511);
         check("stall in_ready", 0, 32'(pre_rdy[0]), 32'h0);
         check("stall out_data", 0, 32'(od[0]), 32'hA5);
         check("stall out_chan", 0, 32'(oc[0]), 32'h1);
      end
      cycle(4'b1111, 1'b1, 32'h3322A511);
      check("unstall in_ready", 0, 32'(pre_rdy[0]), 32'b0100);
      check("unstall out_data", 0, 32'(od[0]), 32'h22);

      // Lone requester ch2 with BURST_LEN 2: accepted every cycle, grant drops at each burst end.
      do_reset();
      for (int i = 0; i < 6; i++) begin
         cycle(4'b0100, 1'b1, 32'h44332211);
         check("solo in_ready",  1, 32'(pre_rdy[1]), 32'b0100);
         check("solo out_chan",  1, 32'(oc[1]), 32'h2);
         check("solo out_valid", 1, 32'(ov[1]), 32'h1);
         check("solo grant",     1, 32'(gnt[1]), (i % 2 == 0) ? 32'b0100 : 32'h0);
      end

      // Owner ch1 drops valid mid-burst while ch3 requests: switch with no bubble, new burst of 4.
      do_reset();
      cycle(4'b0010, 1'b1, 32'h44332211);
      check("switch owner", 2, 32'(gnt[2]), 32'b0010);
      cycle(4'b1000, 1'b1, 32'h44332211);
      check("switch in_ready",  2, 32'(pre_rdy[2]), 32'b1000);
      check("switch grant",     2, 32'(gnt[2]), 32'b1000);
      check("switch out_chan",  2, 32'(oc[2]), 32'h3);
      check("switch out_valid", 2, 32'(ov[2]), 32'h1);
      cycle(4'b1000, 1'b1, 32'h44332211);
      check("switch burst2", 2, 32'(gnt[2]), 32'b1000);
      cycle(4'b1000, 1'b1, 32'h44332211);
      check("switch burst3", 2, 32'(gnt[2]), 32'b1000);
      cycle(4'b1000, 1'b1, 32'h44332211);
      check("switch burst4", 2, 32'(gnt[2]), 32'h0);

      // Randomised traffic against the model.
      do_reset();
      for (int i = 0; i < 400; i++) begin
         cycle(4'($urandom), ($urandom_range(0, 3) != 0), $urandom);
      end

      // Reset in the middle of a held transfer.
      do_reset();
      cycle(4'b0100, 1'b0, 32'h44332211);
      check("pre-reset grant",     1, 32'(gnt[1]), 32'b0100);
      check("pre-reset out_valid", 1, 32'(ov[1]), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      for (int b = 0; b < 3; b++) begin
         check("midreset out_valid", b, 32'(ov[b]), 32'h0);
         check("midreset grant",     b, 32'(gnt[b]), 32'h0);
         check("midreset in_ready",  b, 32'(rdy[b]), 32'h0);
      end
      model_reset();
      in_valid = 4'b0; out_ready = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      cycle(4'b1111, 1'b1, 32'h44332211);
      check("post-reset in_ready", 1, 32'(pre_rdy[1]), 32'b0001);
      check("post-reset out_chan", 1, 32'(oc[1]), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
